dplca_txop_monitor: RTL and testbench



---
 rtl/dplca_txop_monitor.sv | 156 +++++++++++++++
 tb/tb_dplca_txop_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dplca_txop_monitor.sv
// DPLCA TXOP monitor: follows the PLCA cycle from beacons and carrier activity,
// numbers each transmit opportunity and reports its ID and claim status on a one-cycle end pulse.
module dplca_txop_monitor #(
  parameter int unsigned TO_TIMER = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plca_en,
  input  logic       beacon_det,
  input  logic       crs,
  input  logic [7:0] node_count,
  output logic       dplca_txop_end,
  output logic [7:0] dplca_txop_id,
  output logic [1:0] dplca_txop_claim,
  output logic [2:0] txop_monitor_state
);

  typedef enum logic [2:0] {
    DISABLED    = 3'b000,
    WAIT_BEACON = 3'b001,
    TO_WAIT     = 3'b010,
    ACTIVE      = 3'b011,
    TXOP_END    = 3'b100
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TO_TIMER - 1);

  state_e      state_q, state_d;
  logic [7:0]  curId_q, curId_d;
  logic [15:0] toCnt_q, toCnt_d;
  logic        pendClaim_q, pendClaim_d;
  logic        txopEnd_q, txopEnd_d;
  logic [7:0]  txopId_q, txopId_d;
  logic [1:0]  txopClaim_q, txopClaim_d;

  logic [7:0]  effLast;
  logic        lastTxop;

  // A node_count of zero still means one TXOP; ">=" also stops cur_id from wrapping
  // if node_count shrinks in the middle of a cycle.
  assign effLast  = (node_count == 8'd0) ? 8'd0 : node_count - 8'd1;
  assign lastTxop = (curId_q >= effLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DISABLED;
      curId_q     <= 8'd0;
      toCnt_q     <= 16'd0;
      pendClaim_q <= 1'b0;
      txopEnd_q   <= 1'b0;
      txopId_q    <= 8'd0;
      txopClaim_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      curId_q     <= curId_d;
      toCnt_q     <= toCnt_d;
      pendClaim_q <= pendClaim_d;
      txopEnd_q   <= txopEnd_d;
      txopId_q    <= txopId_d;
      txopClaim_q <= txopClaim_d;
    end
  end

  // A beacon restarts the cycle from any active state and beats carrier and timeout.
  always_comb begin
    state_d = state_q;
    if (!plca_en) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED:    state_d = WAIT_BEACON;
        WAIT_BEACON: if (beacon_det) state_d = TO_WAIT;
        TO_WAIT: begin
          if (beacon_det)              state_d = TO_WAIT;
          else if (crs)                state_d = ACTIVE;
          else if (toCnt_q == TO_LAST) state_d = TXOP_END;
        end
        ACTIVE: begin
          if (beacon_det) state_d = TO_WAIT;
          else if (!crs)  state_d = TXOP_END;
        end
        TXOP_END: begin
          if (beacon_det)    state_d = TO_WAIT;
          else if (lastTxop) state_d = WAIT_BEACON;
          else               state_d = TO_WAIT;
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_comb begin
    curId_d     = curId_q;
    toCnt_d     = toCnt_q;
    pendClaim_d = pendClaim_q;
    txopEnd_d   = 1'b0;
    txopId_d    = txopId_q;
    txopClaim_d = txopClaim_q;

    if (state_d == DISABLED) begin
      curId_d     = 8'd0;
      toCnt_d     = 16'd0;
      pendClaim_d = 1'b0;
      txopId_d    = 8'd0;
      txopClaim_d = 2'b00;
    end else begin
      case (state_q)
        WAIT_BEACON: begin
          if (beacon_det) begin
            curId_d = 8'd0;
            toCnt_d = 16'd0;
          end
        end
        TO_WAIT: begin
          if (beacon_det) begin
            curId_d = 8'd0;
            toCnt_d = 16'd0;
          end else begin
            toCnt_d = toCnt_q + 16'd1;
            if (crs)                     pendClaim_d = 1'b1;
            else if (toCnt_q == TO_LAST) pendClaim_d = 1'b0;
          end
        end
        ACTIVE: begin
          if (beacon_det) begin
            curId_d = 8'd0;
            toCnt_d = 16'd0;
          end
        end
        TXOP_END: begin
          if (beacon_det) begin
            curId_d = 8'd0;
            toCnt_d = 16'd0;
          end else if (!lastTxop) begin
            curId_d = curId_q + 8'd1;
            toCnt_d = 16'd0;
          end
        end
        default: ;
      endcase

      // Report values are captured on entry so they line up with the TXOP_END cycle.
      if (state_d == TXOP_END) begin
        txopEnd_d   = 1'b1;
        txopId_d    = curId_q;
        txopClaim_d = {1'b0, pendClaim_d};
      end
    end
  end

  assign dplca_txop_end     = txopEnd_q;
  assign dplca_txop_id      = txopId_q;
  assign dplca_txop_claim   = txopClaim_q;
  assign txop_monitor_state = state_q;

endmodule

// File: tb/tb_dplca_txop_monitor.sv
// Scoreboard bench for dplca_txop_monitor: scenarios push expected end pulses
// (ID, claim, cycle) and a negedge monitor pops and compares them.
module tb_dplca_txop_monitor;

  localparam int T = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       plca_en = 1'b0;
  logic       beacon_det = 1'b0;
  logic       crs = 1'b0;
  logic [7:0] node_count = 8'd0;
  logic       dplca_txop_end;
  logic [7:0] dplca_txop_id;
  logic [1:0] dplca_txop_claim;
  logic [2:0] txop_monitor_state;

  int unsigned cyc = 0;
  int nChecks = 0;
  int nFails = 0;
  logic prevEnd = 1'b0;

  typedef struct {
    logic [7:0]  id;
    logic [1:0]  claim;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  dplca_txop_monitor #(.TO_TIMER(T)) dut (
    .clk(clk),
    .reset(reset),
    .plca_en(plca_en),
    .beacon_det(beacon_det),
    .crs(crs),
    .node_count(node_count),
    .dplca_txop_end(dplca_txop_end),
    .dplca_txop_id(dplca_txop_id),
    .dplca_txop_claim(dplca_txop_claim),
    .txop_monitor_state(txop_monitor_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every end pulse must match the oldest expectation in ID, claim and arrival cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dplca_txop_end !== 1'b0) begin
      nChecks++;
      if (prevEnd) begin
        nFails++;
        $display("[TB] FAIL pulse_spacing: end high on consecutive cycles at cyc %0d, required a gap", cyc);
      end
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("[TB] FAIL unexpected_pulse: end=%b id=%0d at cyc %0d, required no pulse", dplca_txop_end, dplca_txop_id, cyc);
      end else begin
        e = sb.pop_front();
        nChecks++;
        if (dplca_txop_id !== e.id) begin
          nFails++;
          $display("[TB] FAIL pulse_id: got %0d expected %0d at cyc %0d", dplca_txop_id, e.id, cyc);
        end
        nChecks++;
        if (dplca_txop_claim !== e.claim) begin
          nFails++;
          $display("[TB] FAIL pulse_claim (id %0d): got %b expected %b", e.id, dplca_txop_claim, e.claim);
        end
        nChecks++;
        if (cyc !== e.at) begin
          nFails++;
          $display("[TB] FAIL pulse_cycle (id %0d): got cyc %0d expected cyc %0d", e.id, cyc, e.at);
        end
      end
    end
    prevEnd = (dplca_txop_end !== 1'b0);
  end

  task automatic push_exp(input logic [7:0] id, input logic [1:0] claim, input int unsigned at);
    exp_t e;
    e.id = id;
    e.claim = claim;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Returns the bench cycle number of the cycle in which beacon_det was high.
  task automatic send_beacon(output int unsigned b);
    @(negedge clk);
    beacon_det = 1'b1;
    b = cyc;
    @(negedge clk);
    beacon_det = 1'b0;
  endtask

  task automatic wait_drain(input int limit, output bit timedOut);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    timedOut = (sb.size() != 0);
    if (timedOut) sb.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd0) begin nFails++; $display("[TB] FAIL reset_state: got %0d expected 0", txop_monitor_state); end
    nChecks++; if (dplca_txop_end !== 1'b0) begin nFails++; $display("[TB] FAIL reset_end: got %b expected 0", dplca_txop_end); end
    nChecks++; if (dplca_txop_id !== 8'd0) begin nFails++; $display("[TB] FAIL reset_id: got %0d expected 0", dplca_txop_id); end
    nChecks++; if (dplca_txop_claim !== 2'b00) begin nFails++; $display("[TB] FAIL reset_claim: got %b expected 00", dplca_txop_claim); end
    plca_en = 1'b1;
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd0) begin nFails++; $display("[TB] FAIL reset_priority: got %0d expected 0", txop_monitor_state); end
    reset = 1'b0;
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL enable_state: got %0d expected 1", txop_monitor_state); end
  endtask

  task automatic test_unclaimed;
    int unsigned b;
    bit to;
    node_count = 8'd3;
    send_beacon(b);
    for (int i = 0; i < 3; i++) push_exp(8'(i), 2'b00, b + (i + 1) * (T + 1));
    wait_drain(200, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL unclaimed_drain: pulses still pending, expected all 3"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL unclaimed_state: got %0d expected 1", txop_monitor_state); end
    nChecks++; if (dplca_txop_id !== 8'd2) begin nFails++; $display("[TB] FAIL unclaimed_id_hold: got %0d expected 2", dplca_txop_id); end
  endtask

  task automatic test_claimed;
    int unsigned b;
    bit to;
    node_count = 8'd3;
    send_beacon(b);
    push_exp(8'd0, 2'b00, b + 33);
    push_exp(8'd1, 2'b01, b + 50);
    push_exp(8'd2, 2'b00, b + 83);
    wait_until(b + 39);
    crs = 1'b1;
    wait_until(b + 49);
    crs = 1'b0;
    wait_drain(200, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL claimed_drain: pulses still pending, expected all 3"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL claimed_state: got %0d expected 1", txop_monitor_state); end
  endtask

  task automatic test_claim_at_last;
    int unsigned b;
    bit to;
    node_count = 8'd1;
    send_beacon(b);
    push_exp(8'd0, 2'b01, b + 34);
    wait_until(b + 32);
    crs = 1'b1;
    wait_until(b + 33);
    crs = 1'b0;
    wait_drain(100, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL last_claim_drain: pulse still pending, expected 1"); end
    nChecks++; if (dplca_txop_claim !== 2'b01) begin nFails++; $display("[TB] FAIL last_claim_value: got %b expected 01", dplca_txop_claim); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL last_claim_state: got %0d expected 1", txop_monitor_state); end
  endtask

  task automatic test_back_to_back;
    int unsigned b;
    bit to;
    node_count = 8'd3;
    send_beacon(b);
    crs = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(8'(i), 2'b01, b + 3 * (i + 1));
    for (int k = 2; k <= 8; k++) begin
      wait_until(b + k);
      crs = (k % 3 != 2);
    end
    wait_drain(50, to);
    crs = 1'b0;
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL b2b_drain: pulses still pending, expected all 3"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL b2b_state: got %0d expected 1", txop_monitor_state); end
  endtask

  task automatic test_node_count_zero;
    int unsigned b;
    bit to;
    node_count = 8'd0;
    send_beacon(b);
    push_exp(8'd0, 2'b00, b + 33);
    wait_drain(100, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL nc0_drain: pulse still pending, expected 1"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL nc0_state: got %0d expected 1", txop_monitor_state); end
  endtask

  task automatic test_node_count_255;
    int unsigned b;
    bit to;
    node_count = 8'd255;
    send_beacon(b);
    for (int i = 0; i < 255; i++) push_exp(8'(i), 2'b00, b + (i + 1) * (T + 1));
    wait_drain(255 * (T + 1) + 100, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL nc255_drain: pulses still pending, expected all 255"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL nc255_state: got %0d expected 1", txop_monitor_state); end
    nChecks++; if (dplca_txop_id !== 8'd254) begin nFails++; $display("[TB] FAIL nc255_last_id: got %0d expected 254", dplca_txop_id); end
  endtask

  task automatic test_beacon_abort;
    int unsigned b;
    bit to;
    node_count = 8'd5;
    send_beacon(b);
    push_exp(8'd0, 2'b00, b + 33);
    push_exp(8'd1, 2'b00, b + 66);
    wait_until(b + 70);
    crs = 1'b1;
    wait_until(b + 75);
    beacon_det = 1'b1;
    crs = 1'b0;
    push_exp(8'd0, 2'b00, b + 108);
    wait_until(b + 76);
    beacon_det = 1'b0;
    wait_drain(150, to);
    nChecks++; if (to) begin nFails++; $display("[TB] FAIL abort_drain: pulses still pending, expected 3"); end
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd2) begin nFails++; $display("[TB] FAIL abort_state: got %0d expected 2", txop_monitor_state); end
  endtask

  task automatic test_disable_and_reset;
    int unsigned b;
    int unsigned bIgnored;
    // Two quick claimed TXOPs, then plca_en drops while TXOP 2 waits.
    node_count = 8'd3;
    send_beacon(b);
    crs = 1'b1;
    push_exp(8'd0, 2'b01, b + 3);
    push_exp(8'd1, 2'b01, b + 6);
    for (int k = 2; k <= 5; k++) begin
      wait_until(b + k);
      crs = (k % 3 != 2);
    end
    wait_until(b + 12);
    nChecks++; if (txop_monitor_state !== 3'd2) begin nFails++; $display("[TB] FAIL dis_pre_state: got %0d expected 2", txop_monitor_state); end
    nChecks++; if (dplca_txop_id !== 8'd1) begin nFails++; $display("[TB] FAIL dis_pre_id: got %0d expected 1", dplca_txop_id); end
    nChecks++; if (dplca_txop_claim !== 2'b01) begin nFails++; $display("[TB] FAIL dis_pre_claim: got %b expected 01", dplca_txop_claim); end
    plca_en = 1'b0;
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd0) begin nFails++; $display("[TB] FAIL dis_state: got %0d expected 0", txop_monitor_state); end
    nChecks++; if (dplca_txop_id !== 8'd0) begin nFails++; $display("[TB] FAIL dis_id: got %0d expected 0", dplca_txop_id); end
    nChecks++; if (dplca_txop_claim !== 2'b00) begin nFails++; $display("[TB] FAIL dis_claim: got %b expected 00", dplca_txop_claim); end
    repeat (5) @(negedge clk);
    send_beacon(bIgnored);
    repeat (35) @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd0) begin nFails++; $display("[TB] FAIL dis_hold_state: got %0d expected 0", txop_monitor_state); end
    nChecks++; if (sb.size() != 0) begin nFails++; $display("[TB] FAIL dis_pending: got %0d pending expected 0", sb.size()); end

    // Re-enable, claim two TXOPs, then reset in the middle of TXOP 2's carrier.
    plca_en = 1'b1;
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL reen_state: got %0d expected 1", txop_monitor_state); end
    send_beacon(b);
    crs = 1'b1;
    push_exp(8'd0, 2'b01, b + 3);
    push_exp(8'd1, 2'b01, b + 6);
    for (int k = 2; k <= 5; k++) begin
      wait_until(b + k);
      crs = (k % 3 != 2);
    end
    wait_until(b + 8);
    crs = 1'b1;
    wait_until(b + 12);
    nChecks++; if (txop_monitor_state !== 3'd3) begin nFails++; $display("[TB] FAIL rst_pre_state: got %0d expected 3", txop_monitor_state); end
    nChecks++; if (dplca_txop_claim !== 2'b01) begin nFails++; $display("[TB] FAIL rst_pre_claim: got %b expected 01", dplca_txop_claim); end
    reset = 1'b1;
    @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd0) begin nFails++; $display("[TB] FAIL rst_state: got %0d expected 0", txop_monitor_state); end
    nChecks++; if (dplca_txop_end !== 1'b0) begin nFails++; $display("[TB] FAIL rst_end: got %b expected 0", dplca_txop_end); end
    nChecks++; if (dplca_txop_id !== 8'd0) begin nFails++; $display("[TB] FAIL rst_id: got %0d expected 0", dplca_txop_id); end
    nChecks++; if (dplca_txop_claim !== 2'b00) begin nFails++; $display("[TB] FAIL rst_claim: got %b expected 00", dplca_txop_claim); end
    reset = 1'b0;
    crs = 1'b0;
    repeat (40) @(negedge clk);
    nChecks++; if (txop_monitor_state !== 3'd1) begin nFails++; $display("[TB] FAIL rst_after_state: got %0d expected 1", txop_monitor_state); end
    nChecks++; if (sb.size() != 0) begin nFails++; $display("[TB] FAIL rst_pending: got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_unclaimed();
    test_claimed();
    test_claim_at_last();
    test_back_to_back();
    test_node_count_zero();
    test_node_count_255();
    test_beacon_abort();
    test_disable_and_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    nFails++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before it");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
